ll2_h_hdecimate: RTL
====================

// Module: ll2_h_hdecimate
// PURPOSE
//   Horizontal 2:1 decimating low-pass stage: averages each horizontal pixel pair of a raster stream.
//   Sits directly upstream of LL2_H in the visual-saliency level-2 pyramid and feeds its In1 port.
//   Input and output use the actor token handshake: *_DATA, *_SEND, *_ACK, *_COUNT, plus Out1_RDY.
// PARAMETERS
//   DATA_W  16   pixel width, in bits, on In1 and Out1
//   WIDTH   512  input row length in pixels; legal range is 1..65535, and odd values are allowed
// PORTS
//   CLK         in   1       sole clock; all logic is clocked on its rising edge
//   RESET       in   1       synchronous, active-high reset
//   In1_DATA    in   DATA_W  input pixel
//   In1_SEND    in   1       upstream offers In1_DATA this cycle
//   In1_COUNT   in   16      token count offered; this block consumes 1 token per transfer
//   In1_ACK     out  1       input token consumed this cycle
//   Out1_RDY    in   1       downstream can accept a token this cycle
//   Out1_ACK    in   1       downstream consumed the token; informational only
//   Out1_DATA   out  DATA_W  decimated pixel
//   Out1_SEND   out  1       output token valid this cycle
//   Out1_COUNT  out  16      constant 16'h1
// BEHAVIOUR
//   Reset values: In1_ACK=0, Out1_SEND=0, Out1_DATA=0, col=0, state=S_EVEN, out_vld=0.
//     Out1_COUNT=1 at all times.
//   Reset mid-operation: any held pixel and any pending output token are discarded.
//     The first pixel after reset is treated as column 0.
//   Input transfer: a token transfers in a cycle where In1_SEND=1 and In1_ACK=1.
//     In1_ACK is combinational: In1_ACK = In1_SEND & accept_ok. It never asserts without In1_SEND.
//   Output transfer: Out1_SEND = out_vld & Out1_RDY.
//     The token transfers in that cycle, and out_vld clears unless it is reloaded in the same cycle.
//   FSM states:
//     S_EVEN: accept_ok=1. On transfer, latch the pixel into a_q and go to S_ODD.
//       Exception: if col==WIDTH-1 (odd WIDTH, last pixel of the row), pair the pixel with itself.
//       That case emits like S_ODD and stays in S_EVEN.
//     S_ODD: accept_ok = ~out_vld | Out1_SEND.
//       On transfer, load out_q = avg(a_q, In1_DATA), set out_vld=1, go to S_EVEN.
//   col counts accepted pixels. It wraps from WIDTH-1 to 0.
//     A row boundary forces pairing to restart, so no pair ever spans two rows.
//   Arithmetic: sum is DATA_W+1 bits, so it never overflows.
//     avg = sum>>1 (truncate), or (sum+1)>>1 when rounding is enabled (see CONFIGURATION).
//   Latency: Out1_SEND can first assert in the cycle after the second pixel of a pair is accepted.
//   Throughput: sustains 1 input per cycle and 1 output every 2 cycles while Out1_RDY=1.
//   Backpressure: Out1_RDY=0 with out_vld=1 stalls only the second pixel of the next pair.
//     The first pixel is still accepted into a_q.
//   Simultaneous drain and reload in S_ODD: the old token leaves and the new one loads in that cycle.
//     No bubble is inserted and no token is lost.
//   Out1_DATA holds its last value while Out1_SEND=0.
// CONFIGURATION
//   LL2_HDEC_ROUND_EN defined: avg = (a+b+1)>>1, i.e. round half up.
//   LL2_HDEC_ROUND_EN undefined (default): avg = (a+b)>>1, i.e. truncate.
//   All other behaviour is identical in both builds.
// STRUCTURE
//   Shared package ripl_stream_pkg holds:
//     DATA_W default, COUNT_W=16, the COUNT_ONE=16'h1 constant, and the state encoding S_EVEN/S_ODD.
//   One sub-module: ll2_hdec_avg, a combinational (DATA_W+1)-bit adder and shifter.
//     It contains the LL2_HDEC_ROUND_EN switch.
//   The FSM, column counter and output register stay in the top level.
// TESTING
//   1. WIDTH=4; feed 10,20,30,41 with Out1_RDY=1 -> outputs 15,35. With ROUND_EN, outputs 15,36.
//   2. WIDTH=3; feed rows 2,4,7 | 8,6,1 -> outputs 3,7,7,1. Pairs never cross rows.
//   3. Feed 0xFFFF,0xFFFF -> output 0xFFFF, showing no overflow in either build.
//   4. Hold Out1_RDY=0 for 5 cycles with In1_SEND=1 -> one token held, a_q loaded.
//      In1_ACK=0 on the 2nd pixel; on release, tokens emerge in order with no loss or duplication.
//   5. Assert RESET mid-pair (a_q held, out_vld=1) -> Out1_SEND=0 on the next cycle.
//      The next pixel starts at col=0.
//   6. Random In1_SEND/Out1_RDY for 10k pixels against a reference model -> exact match.
//      In1_ACK never asserts without In1_SEND, and Out1_SEND never asserts without Out1_RDY.

Source files
------------

// File: rtl/ripl_stream_pkg.sv
// ----------------------------------------------------------------------------
// ripl_stream_pkg
//   Shared definitions for actor-style token streams in the level-2 saliency
//   pyramid.
//   Contents:
//     DATA_W_DEF    default pixel width
//     COUNT_W       width of the *_COUNT token-count fields
//     COUNT_ONE     constant token count of one
//     hdec_state_e  pairing state of the horizontal decimator
//                   (S_EVEN: waiting for the first pixel of a pair,
//                    S_ODD:  first pixel held, waiting for the second)
// ----------------------------------------------------------------------------
package ripl_stream_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int COUNT_W    = 16;

  localparam logic [COUNT_W-1:0] COUNT_ONE = 16'h1;

  typedef enum logic [0:0] {
    S_EVEN = 1'b0,
    S_ODD  = 1'b1
  } hdec_state_e;

endpackage

// File: rtl/ll2_hdec_avg.sv
// ----------------------------------------------------------------------------
// ll2_hdec_avg
//   Combinational average of two pixels. The sum is carried at DATA_W+1 bits,
//   so neither the add nor the rounding increment can overflow.
//   Build option: define LL2_HDEC_ROUND_EN for round-half-up
//   ((a+b+1)>>1); left undefined the result truncates ((a+b)>>1).
//   Ports:
//     a_i    first pixel of the pair
//     b_i    second pixel of the pair
//     avg_o  averaged pixel
// ----------------------------------------------------------------------------
module ll2_hdec_avg #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] avg_o
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum = {1'b0, a_i} + {1'b0, b_i};
`ifdef LL2_HDEC_ROUND_EN
    sum = sum + {{DATA_W{1'b0}}, 1'b1};
`else
    sum = sum;
`endif
    avg_o = sum[DATA_W:1];
  end

endmodule

// File: rtl/ll2_h_hdecimate.sv
// ----------------------------------------------------------------------------
// ll2_h_hdecimate
//   Horizontal 2:1 decimating low-pass stage. Each horizontal pixel pair of a
//   raster stream is averaged into one output pixel. Pairing restarts at every
//   row boundary; with an odd WIDTH the last pixel of a row is paired with
//   itself.
//   Build option: LL2_HDEC_ROUND_EN selects round-half-up averaging
//   (see ll2_hdec_avg); default build truncates.
//
//   Handshake: an input token moves in a cycle where In1_SEND=1 and
//   In1_ACK=1 (In1_ACK is combinational and never asserts without In1_SEND);
//   an output token moves in a cycle where Out1_SEND=1, and Out1_SEND is
//   only ever asserted together with Out1_RDY. Out1_ACK is informational.
//
//   Ports:
//     CLK, RESET   clock, synchronous active-high reset
//     In1_DATA     input pixel
//     In1_SEND     upstream offers a pixel
//     In1_COUNT    offered token count (one token taken per transfer)
//     In1_ACK      input pixel consumed this cycle
//     Out1_RDY     downstream can take a token
//     Out1_ACK     downstream consumed a token (unused)
//     Out1_DATA    decimated pixel
//     Out1_SEND    output token valid and taken this cycle
//     Out1_COUNT   constant 1
//     dbg_state_o  current pairing state (hdec_state_e encoding)
// ----------------------------------------------------------------------------
module ll2_h_hdecimate
  import ripl_stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int WIDTH  = 512
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [DATA_W-1:0]  In1_DATA,
  input  logic               In1_SEND,
  input  logic [COUNT_W-1:0] In1_COUNT,
  output logic               In1_ACK,
  input  logic               Out1_RDY,
  input  logic               Out1_ACK,
  output logic [DATA_W-1:0]  Out1_DATA,
  output logic               Out1_SEND,
  output logic [COUNT_W-1:0] Out1_COUNT,
  output logic               dbg_state_o
);

  localparam logic [COUNT_W-1:0] LAST_COL = COUNT_W'(WIDTH - 1);

  hdec_state_e        state_q, state_d;
  logic [COUNT_W-1:0] col_q, col_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  out_q, out_d;
  logic               out_vld_q, out_vld_d;

  logic              last_col;
  logic              out_send;
  logic              slot_free;
  logic              emit_pos;
  logic              accept_ok;
  logic              in_xfer;
  logic [DATA_W-1:0] avg_a;
  logic [DATA_W-1:0] avg_y;

  // The token count fields carry no information for a 1-token-per-transfer
  // actor; they are folded away here.
  logic unused_ok;
  assign unused_ok = ^{In1_COUNT, Out1_ACK};

  assign last_col  = (col_q == LAST_COL);
  assign out_send  = out_vld_q & Out1_RDY;
  // The output slot can take a new token if empty or draining this cycle,
  // which lets drain and reload happen together without a bubble.
  assign slot_free = ~out_vld_q | out_send;
  // A pixel produces an output either as the second of a pair or as the
  // self-paired last pixel of an odd-length row.
  assign emit_pos  = (state_q == S_ODD) | last_col;
  // Only pixels that produce an output depend on downstream space; the first
  // pixel of a pair is always taken into a_q.
  assign accept_ok = emit_pos ? slot_free : 1'b1;
  assign in_xfer   = In1_SEND & accept_ok;
  assign avg_a     = (state_q == S_ODD) ? a_q : In1_DATA;

  ll2_hdec_avg #(
    .DATA_W (DATA_W)
  ) u_avg (
    .a_i   (avg_a),
    .b_i   (In1_DATA),
    .avg_o (avg_y)
  );

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    a_d       = a_q;
    out_d     = out_q;
    out_vld_d = out_vld_q;

    if (out_send) begin
      out_vld_d = 1'b0;
    end

    if (in_xfer) begin
      col_d = last_col ? '0 : col_q + 1'b1;
      if (emit_pos) begin
        out_d     = avg_y;
        out_vld_d = 1'b1;
        state_d   = S_EVEN;
      end else begin
        a_d     = In1_DATA;
        state_d = S_ODD;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_EVEN;
      col_q     <= '0;
      a_q       <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      a_q       <= a_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign In1_ACK     = in_xfer;
  assign Out1_SEND   = out_send;
  assign Out1_DATA   = out_q;
  assign Out1_COUNT  = COUNT_ONE;
  assign dbg_state_o = state_q;

endmodule
